// File: rtl/tlul_sram_slave.sv
// TL-UL slave fronting a single-port byte-writable SRAM window.
// Responses are queued in a small FIFO so that back-pressure on channel D stalls channel A.
module tlul_sram_slave #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                SRC_W     = 3,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RSP_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               a_valid,
    output logic                               a_ready,
    input  logic [2:0]                         a_opcode,
    input  logic [2:0]                         a_param,
    input  logic [3:0]                         a_size,
    input  logic [DATA_W/8-1:0]                a_mask,
    input  logic [ADDR_W-1:0]                  a_address,
    input  logic [DATA_W-1:0]                  a_data,
    input  logic [SRC_W-1:0]                   a_source,
    output logic                               d_valid,
    input  logic                               d_ready,
    output logic [2:0]                         d_opcode,
    output logic [2:0]                         d_param,
    output logic [3:0]                         d_size,
    output logic [DATA_W-1:0]                  d_data,
    output logic [SRC_W-1:0]                   d_source,
    output logic [1:0]                         d_sink,
    output logic                               d_error,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     rsp_count
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [3:0]        size;
        logic [SRC_W-1:0]  source;
        logic              error;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              fifo_mem [RSP_DEPTH];
    rsp_t              push_ent, head;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_en_q;

    logic [ADDR_W-1:0] offset, align_mask;
    logic [IDX_W-1:0]  widx;
    logic [BYTES-1:0]  full_mask;
    logic              opc_ok, size_ok, align_ok, range_ok, mask_ok, req_err;
    logic              is_get, push, pop;
    logic              unused_param;

    assign unused_param = ^a_param;

    // ---------------- request decode ----------------
    assign offset     = a_address - BASE_ADDR;
    assign widx       = offset[OFF_W +: IDX_W];
    assign is_get     = (a_opcode == 3'd4);
    assign opc_ok     = (a_opcode == 3'd0) || (a_opcode == 3'd1) || is_get;
    assign size_ok    = (a_size <= 4'(OFF_W));
    assign align_mask = ~({ADDR_W{1'b1}} << a_size);
    assign align_ok   = ((a_address & align_mask) == '0);
    assign range_ok   = (a_address >= BASE_ADDR) && ((offset >> (OFF_W + IDX_W)) == '0);

    // Byte lanes a PutFullData of this size/alignment must enable.
    always_comb begin
        full_mask = '0;
        for (int i = 0; i < BYTES; i++)
            full_mask[i] = (i >= int'(a_address[OFF_W-1:0])) &&
                           (i <  int'(a_address[OFF_W-1:0]) + (1 << a_size));
    end

    assign mask_ok = (a_opcode != 3'd0) || (a_mask == full_mask);
    assign req_err = !(opc_ok && size_ok && align_ok && range_ok && mask_ok);

    assign a_ready = rst_n && rdy_en_q && (cnt_q < CNT_W'(RSP_DEPTH));
    assign d_valid = (cnt_q != '0);
    assign push    = a_valid && a_ready;
    assign pop     = d_valid && d_ready;

    // ---------------- memory (not reset) ----------------
    always_ff @(posedge clk) begin
        if (push && !req_err && !is_get)
            for (int i = 0; i < BYTES; i++)
                if (a_mask[i]) mem[widx][i*8 +: 8] <= a_data[i*8 +: 8];
    end

    always_comb begin
        push_ent        = '0;
        push_ent.opcode = is_get ? 3'd1 : 3'd0;
        push_ent.size   = a_size;
        push_ent.source = a_source;
        push_ent.error  = req_err;
        push_ent.data   = (is_get && !req_err) ? mem[widx] : '0;
    end

    // ---------------- response FIFO ----------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_ent;
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    // rdy_en_q delays a_ready to the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head fields are gated so nothing stale leaks out while the FIFO is empty.
    assign head      = fifo_mem[rd_ptr_q];
    assign d_opcode  = d_valid ? head.opcode : '0;
    assign d_size    = d_valid ? head.size   : '0;
    assign d_source  = d_valid ? head.source : '0;
    assign d_error   = d_valid ? head.error  : 1'b0;
    assign d_data    = d_valid ? head.data   : '0;
    assign d_param   = '0;
    assign d_sink    = '0;
    assign rsp_count = cnt_q;
endmodule

// File: tb/tb_tlul_sram_slave.sv
// Bench for tlul_sram_slave: directed scenarios plus random traffic against a queue/array model.
module tb_tlul_sram_slave;
    localparam int          DATA_W = 32, ADDR_W = 32, SRC_W = 3, DEPTH = 256, RSP_DEPTH = 2;
    localparam logic [31:0] BASE   = 32'h0;

    logic        clk, rst_n;
    logic        a_valid, a_ready, d_valid, d_ready, d_error;
    logic [2:0]  a_opcode, a_param, d_opcode, d_param, a_source, d_source;
    logic [3:0]  a_size, d_size, a_mask;
    logic [31:0] a_address, a_data, d_data;
    logic [1:0]  d_sink, rsp_count;

    tlul_sram_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .DEPTH(DEPTH),
                      .BASE_ADDR(BASE), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
        .a_source(a_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_data(d_data), .d_source(d_source), .d_sink(d_sink),
        .d_error(d_error), .rsp_count(rsp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [2:0]  src;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [DEPTH];
    int          checks = 0;
    int          errors = 0;

    function automatic logic model_err(input logic [2:0] op, input logic [3:0] size,
                                       input logic [3:0] mask, input logic [31:0] addr);
        int nb;
        logic [3:0] fm;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 4'd2) return 1'b1;
        nb = 1 << size;
        if ((addr % nb) != 0) return 1'b1;
        if (longint'(addr) < longint'(BASE) || longint'(addr) >= longint'(BASE) + DEPTH * 4) return 1'b1;
        fm = 4'(((1 << nb) - 1) << (addr % 4));
        if (op == 3'd0 && mask != fm) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [3:0] size, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] data, input logic [2:0] src);
        a_valid = 1'b1; a_opcode = op; a_size = size; a_mask = mask;
        a_address = addr; a_data = data; a_source = src; a_param = 3'($urandom_range(0, 7));
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_ready, d_valid, rsp_count, d_opcode, d_param, d_size, d_data, d_source, d_sink, d_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b cnt=%0d data=%h exp all zero", a_ready, d_valid, rsp_count, d_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++; $display("FAIL reset_release_early got a_ready=%b exp 0", a_ready);
        end
        tick();
        checks++;
        if (a_ready !== 1'b1 || rsp_count !== 2'd0) begin
            errors++; $display("FAIL reset_release_edge got a_ready=%b cnt=%0d exp 1 0", a_ready, rsp_count);
        end
    endtask

    // Fill all words back to back then read them all back, one accept per cycle.
    task automatic test_continuous();
        d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[i] = $urandom;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) drive(3'd0, 4'd2, 4'hF, BASE + 32'(i * 4), mm[i], 3'(i % 8));
            else idle();
            checks++;
            if (i < DEPTH && a_ready !== 1'b1) begin
                errors++; $display("FAIL cont_put_ready i=%0d got %b exp 1", i, a_ready);
            end
            if (i > 0) begin
                checks++;
                if ({d_valid, rsp_count, d_opcode, d_source, d_error} !== {1'b1, 2'd1, 3'd0, 3'((i - 1) % 8), 1'b0}) begin
                    errors++;
                    $display("FAIL cont_put_rsp i=%0d got vld=%b cnt=%0d op=%0d src=%0d err=%b exp 1 1 0 %0d 0",
                             i, d_valid, rsp_count, d_opcode, d_source, d_error, (i - 1) % 8);
                end
            end
            tick();
        end
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) drive(3'd4, 4'd2, 4'h0, BASE + 32'(i * 4), 32'h0, 3'(i % 8));
            else idle();
            if (i > 0) begin
                checks++;
                if ({d_valid, rsp_count, d_opcode, d_error, d_data} !== {1'b1, 2'd1, 3'd1, 1'b0, mm[i - 1]}) begin
                    errors++;
                    $display("FAIL cont_get_rsp i=%0d got vld=%b cnt=%0d op=%0d data=%h exp 1 1 1 %h",
                             i, d_valid, rsp_count, d_opcode, d_data, mm[i - 1]);
                end
            end
            tick();
        end
        checks++;
        if (d_valid !== 1'b0) begin
            errors++; $display("FAIL cont_drain got d_valid=%b exp 0", d_valid);
        end
    endtask

    task automatic test_put_get();
        drive(3'd0, 4'd2, 4'hF, 32'h10, 32'hDEADBEEF, 3'd2);
        tick();
        drive(3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd0);
        checks++;
        if ({d_valid, d_opcode, d_source, d_error, d_size} !== {1'b1, 3'd0, 3'd2, 1'b0, 4'd2}) begin
            errors++; $display("FAIL putfull_ack got vld=%b op=%0d src=%0d err=%b exp 1 0 2 0", d_valid, d_opcode, d_source, d_error);
        end
        tick();
        idle();
        checks++;
        if ({d_valid, d_opcode, d_error, d_data} !== {1'b1, 3'd1, 1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL put_then_get got op=%0d err=%b data=%h exp 1 0 deadbeef", d_opcode, d_error, d_data);
        end
        tick();
        mm[4] = 32'hDEADBEEF;
    endtask

    task automatic test_partial();
        drive(3'd1, 4'd2, 4'h3, 32'h10, 32'h00001234, 3'd3);
        tick();
        drive(3'd4, 4'd2, 4'h0, 32'h10, 32'h0, 3'd4);
        checks++;
        if ({d_opcode, d_source, d_error} !== {3'd0, 3'd3, 1'b0}) begin
            errors++; $display("FAIL partial_ack got op=%0d src=%0d err=%b exp 0 3 0", d_opcode, d_source, d_error);
        end
        tick();
        idle();
        checks++;
        if (d_data !== 32'hDEAD1234) begin
            errors++; $display("FAIL partial_merge got %h exp dead1234", d_data);
        end
        tick();
        mm[4] = 32'hDEAD1234;
    endtask

    task automatic test_back_to_back();
        d_ready = 1'b0;
        drive(3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd1);
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_acc1 got a_ready=%b exp 1", a_ready); end
        tick();
        drive(3'd4, 4'd2, 4'hF, 32'h14, 32'h0, 3'd2);
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_acc2 got a_ready=%b exp 1", a_ready); end
        tick();
        drive(3'd4, 4'd2, 4'hF, 32'h18, 32'h0, 3'd3);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({a_ready, rsp_count, d_valid, d_source, d_data} !== {1'b0, 2'd2, 1'b1, 3'd1, mm[4]}) begin
                errors++;
                $display("FAIL bp_full k=%0d got rdy=%b cnt=%0d src=%0d data=%h exp 0 2 1 %h", k, a_ready, rsp_count, d_source, d_data, mm[4]);
            end
            if (k == 0) tick();
        end
        d_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass got a_ready=%b exp 0", a_ready); end
        tick();
        checks++;
        if ({a_ready, rsp_count, d_source, d_data} !== {1'b1, 2'd1, 3'd2, mm[5]}) begin
            errors++; $display("FAIL bp_second got rdy=%b cnt=%0d src=%0d data=%h exp 1 1 2 %h", a_ready, rsp_count, d_source, d_data, mm[5]);
        end
        tick();
        idle();
        checks++;
        if ({rsp_count, d_source, d_data} !== {2'd1, 3'd3, mm[6]}) begin
            errors++; $display("FAIL bp_third got cnt=%0d src=%0d data=%h exp 1 3 %h", rsp_count, d_source, d_data, mm[6]);
        end
        tick();
        checks++;
        if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got d_valid=%b exp 0", d_valid); end
    endtask

    task automatic test_errors();
        logic [2:0]  ops   [5] = '{3'd4, 3'd4, 3'd3, 3'd0, 3'd4};
        logic [3:0]  sizes [5] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
        logic [31:0] addrs [5] = '{32'h400, 32'h2, 32'h10, 32'h14, 32'h10};
        logic [3:0]  masks [5] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF};
        logic [2:0]  xop   [5] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], sizes[i], masks[i], addrs[i], 32'hA5A5A5A5, 3'(i));
            tick();
            idle();
            checks++;
            if ({d_valid, d_error, d_data, d_opcode, d_source} !== {1'b1, 1'b1, 32'h0, xop[i], 3'(i)}) begin
                errors++;
                $display("FAIL err_case%0d got vld=%b err=%b data=%h op=%0d exp 1 1 0 %0d", i, d_valid, d_error, d_data, d_opcode, xop[i]);
            end
            tick();
        end
        drive(3'd4, 4'd2, 4'hF, 32'h14, 32'h0, 3'd7);
        tick();
        idle();
        checks++;
        if ({d_error, d_data} !== {1'b0, mm[5]}) begin
            errors++; $display("FAIL err_no_write got err=%b data=%h exp 0 %h", d_error, d_data, mm[5]);
        end
        tick();
    endtask

    task automatic test_random();
        int          r, widx, nb;
        logic [2:0]  op;
        logic [3:0]  size, mask;
        logic [31:0] addr;
        exp_t        e;
        logic        acc, pop;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 19);
            op = (r < 6) ? 3'd0 : (r < 11) ? 3'd1 : (r < 19) ? 3'd4 : 3'($urandom_range(2, 7));
            if (op == 3'd4 && r == 18) op = 3'd3;
            size = ($urandom_range(0, 9) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
            nb = 1 << size;
            widx = $urandom_range(0, DEPTH - 1);
            addr = BASE + 32'(widx * 4);
            if ($urandom_range(0, 7) == 0) addr += 32'($urandom_range(0, 3));
            else if (size < 4'd3) addr += 32'(($urandom_range(0, 3) >> size) << size);
            if ($urandom_range(0, 15) == 0) addr += 32'(DEPTH * 4);
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(((1 << nb) - 1) << (addr % 4));
            if ($urandom_range(0, 9) < 7) drive(op, size, mask, addr, $urandom, 3'($urandom_range(0, 7)));
            else idle();
            d_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (a_ready !== (q.size() < RSP_DEPTH)) begin
                errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, a_ready, q.size() < RSP_DEPTH);
            end
            checks++;
            if ({d_valid, rsp_count} !== {q.size() > 0, 2'(q.size())}) begin
                errors++; $display("FAIL rnd_count c=%0d got vld=%b cnt=%0d exp %0d", c, d_valid, rsp_count, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if ({d_opcode, d_size, d_source, d_error, d_data, d_param, d_sink} !==
                    {q[0].op, q[0].size, q[0].src, q[0].err, q[0].data, 3'd0, 2'd0}) begin
                    errors++;
                    $display("FAIL rnd_head c=%0d got op=%0d sz=%0d src=%0d err=%b data=%h exp %0d %0d %0d %b %h",
                             c, d_opcode, d_size, d_source, d_error, d_data, q[0].op, q[0].size, q[0].src, q[0].err, q[0].data);
                end
            end
            pop = (q.size() > 0) && d_ready;
            acc = a_valid && (q.size() < RSP_DEPTH);
            if (acc) begin
                e.err  = model_err(a_opcode, a_size, a_mask, a_address);
                e.op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
                e.size = a_size;
                e.src  = a_source;
                widx   = int'((a_address - BASE) / 4);
                e.data = (a_opcode == 3'd4 && !e.err) ? mm[widx] : 32'h0;
                if (!e.err && a_opcode != 3'd4)
                    for (int b = 0; b < 4; b++)
                        if (a_mask[b]) mm[widx][b*8 +: 8] = a_data[b*8 +: 8];
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            tick();
        end
        idle();
        d_ready = 1'b1;
        repeat (3) tick();
        q.delete();
        checks++;
        if (d_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain got d_valid=%b exp 0", d_valid); end
    endtask

    task automatic test_reset_midflight();
        d_ready = 1'b0;
        drive(3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd5);
        tick();
        drive(3'd4, 4'd2, 4'hF, 32'h14, 32'h0, 3'd6);
        tick();
        idle();
        checks++;
        if ({d_valid, rsp_count} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL rst_queued got vld=%b cnt=%0d exp 1 2", d_valid, rsp_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({d_valid, rsp_count, a_ready, d_source, d_data, d_opcode, d_size} !== '0) begin
            errors++; $display("FAIL rst_async got vld=%b cnt=%0d rdy=%b src=%0d data=%h exp all 0", d_valid, rsp_count, a_ready, d_source, d_data);
        end
        tick();
        tick();
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_rel_early got a_ready=%b exp 0", a_ready); end
        tick();
        checks++;
        if ({a_ready, rsp_count, d_valid} !== {1'b1, 2'd0, 1'b0}) begin
            errors++; $display("FAIL rst_rel_edge got rdy=%b cnt=%0d vld=%b exp 1 0 0", a_ready, rsp_count, d_valid);
        end
        d_ready = 1'b1;
        drive(3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd4);
        tick();
        idle();
        checks++;
        if ({d_valid, d_data} !== {1'b1, mm[4]}) begin
            errors++; $display("FAIL rst_mem_kept got vld=%b data=%h exp 1 %h", d_valid, d_data, mm[4]);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; d_ready = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_mask = '0; a_address = '0; a_data = '0; a_source = '0;
        test_reset();
        test_continuous();
        test_put_get();
        test_partial();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
